// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles every handshake/bus signal of mem_port_arbiter:
//   fetch side : if_req, if_addr -> if_done, if_rdata, if_stall
//   data side  : dm_req, dm_wr, dm_addr, dm_wdata -> dm_done, dm_rdata, dm_stall
//   memory side: mem_en, mem_wr, mem_addr, mem_wdata <- mem_rdata, mem_ready
//   status     : err (sticky protocol error)
// Modports:
//   slave  - the arbiter itself
//   master - the environment (pipeline requesters plus memory model)
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic [DATA_W-1:0] if_rdata;
  logic              if_stall;
  logic              dm_req;
  logic              dm_wr;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_done;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_stall;
  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              err;

  modport slave (
    input  if_req, if_addr, dm_req, dm_wr, dm_addr, dm_wdata, mem_rdata, mem_ready,
    output if_done, if_rdata, if_stall, dm_done, dm_rdata, dm_stall,
           mem_en, mem_wr, mem_addr, mem_wdata, err
  );

  modport master (
    output if_req, if_addr, dm_req, dm_wr, dm_addr, dm_wdata, mem_rdata, mem_ready,
    input  if_done, if_rdata, if_stall, dm_done, dm_rdata, dm_stall,
           mem_en, mem_wr, mem_addr, mem_wdata, err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-ported, variable-latency memory between the fetch stage
// (read-only) and the memory stage (load/store). One access at a time; the
// granted address/write data are latched so requesters may change them while
// the access is in flight. Data requests win by default.
//
// Ports:
//   clk  - clock, all state on rising edge
//   rst  - asynchronous active-low reset
//   bus  - mem_port_arbiter_if.slave (requester, memory and err signals)
//
// Build option:
//   ARB_FAIRNESS_EN - when defined, a 3-bit starve counter counts data grants
//   made while fetch waits; at STARVE_MAX the next contested grant goes to
//   fetch. When undefined, data has strict priority.
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_port_arbiter_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic              err_q, err_d;
  logic              grant_if_s, grant_dm_s;
  logic              fetch_prio_s;

`ifdef ARB_FAIRNESS_EN
  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);
  logic [2:0] starve_q, starve_d;

  // Fetch wins a contested IDLE cycle once it has been passed over enough times.
  assign fetch_prio_s = (starve_q == STARVE_LIM);

  // Starve counter: cleared by a fetch grant, bumped by a data grant while fetch waits.
  always_comb begin
    starve_d = starve_q;
    if (grant_if_s) begin
      starve_d = 3'd0;
    end else if (grant_dm_s && bus.if_req && (starve_q != STARVE_LIM)) begin
      starve_d = starve_q + 3'd1;
    end else begin
      starve_d = starve_q;
    end
  end

  // Starve counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q <= 3'd0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign fetch_prio_s = 1'b0;
`endif

  // Arbitration, access sequencing and error detection.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wr_d       = wr_q;
    grant_if_s = 1'b0;
    grant_dm_s = 1'b0;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        if (bus.dm_req && !(fetch_prio_s && bus.if_req)) begin
          grant_dm_s = 1'b1;
          state_d    = BUSY_DM;
          addr_d     = bus.dm_addr;
          wdata_d    = bus.dm_wdata;
          wr_d       = bus.dm_wr;
        end else if (bus.if_req) begin
          grant_if_s = 1'b1;
          state_d    = BUSY_IF;
          addr_d     = bus.if_addr;
          wr_d       = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY_IF, BUSY_DM: begin
        if (bus.mem_ready) begin
          state_d = IDLE;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // A completion with nothing outstanding, or an unaligned grant, is sticky.
    err_d = err_q
          | ((state_q == IDLE) & bus.mem_ready)
          | ((grant_if_s | grant_dm_s) & addr_d[0]);
  end

  // State, latched access and error registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= {ADDR_W{1'b0}};
      wdata_q <= {DATA_W{1'b0}};
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
    end
  end

  // Completion is combinational on mem_ready so the requester sees it in the same cycle.
  assign bus.mem_en    = (state_q != IDLE);
  assign bus.mem_wr    = (state_q == BUSY_DM) & wr_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.if_done   = (state_q == BUSY_IF) & bus.mem_ready;
  assign bus.dm_done   = (state_q == BUSY_DM) & bus.mem_ready;
  assign bus.if_rdata  = bus.if_done ? bus.mem_rdata : {DATA_W{1'b0}};
  assign bus.dm_rdata  = bus.dm_done ? bus.mem_rdata : {DATA_W{1'b0}};
  assign bus.if_stall  = bus.if_req & ~bus.if_done;
  assign bus.dm_stall  = bus.dm_req & ~bus.dm_done;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed scenarios with literal expectations, then randomized requesters and
// a random-latency memory, all compared every cycle against a transaction-level
// reference model. Build with or without ARB_FAIRNESS_EN.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;
  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int SMAX = 4;
`ifdef ARB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic clk;
  logic rst;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding transaction record plus latched values.
  bit          m_busy = 1'b0;
  bit          m_who_dm = 1'b0;
  bit          m_wr = 1'b0;
  logic [15:0] m_addr = 16'h0000;
  logic [15:0] m_wdata = 16'h0000;
  bit          m_err = 1'b0;
  int          m_starve = 0;
  int          m_gcnt = 0;
  bit          m_ifd_prev = 1'b0;
  bit          m_dmd_prev = 1'b0;
  bit          chk_en = 1'b0;
  bit          log_en = 1'b0;
  bit          done_log[$];
  bit          e_ifd, e_dmd, take_if;

  always @(negedge clk) begin
    if (chk_en) begin
      if (!rst) begin
        chk("rst_mem_en",  bus.mem_en, 32'd0);
        chk("rst_mem_wr",  bus.mem_wr, 32'd0);
        chk("rst_addr",    bus.mem_addr, 32'd0);
        chk("rst_wdata",   bus.mem_wdata, 32'd0);
        chk("rst_if_done", bus.if_done, 32'd0);
        chk("rst_dm_done", bus.dm_done, 32'd0);
        chk("rst_if_stall", bus.if_stall, 32'(bus.if_req));
        chk("rst_dm_stall", bus.dm_stall, 32'(bus.dm_req));
        chk("rst_err",     bus.err, 32'd0);
        m_busy = 1'b0; m_wr = 1'b0; m_addr = 16'h0000; m_wdata = 16'h0000;
        m_err = 1'b0; m_starve = 0; m_ifd_prev = 1'b0; m_dmd_prev = 1'b0;
      end else begin
        e_ifd = m_busy && !m_who_dm && bus.mem_ready;
        e_dmd = m_busy &&  m_who_dm && bus.mem_ready;
        chk("mem_en",    bus.mem_en, 32'(m_busy));
        chk("mem_wr",    bus.mem_wr, 32'(m_busy && m_wr));
        chk("mem_addr",  bus.mem_addr, 32'(m_addr));
        chk("mem_wdata", bus.mem_wdata, 32'(m_wdata));
        chk("if_done",   bus.if_done, 32'(e_ifd));
        chk("dm_done",   bus.dm_done, 32'(e_dmd));
        chk("if_rdata",  bus.if_rdata, e_ifd ? 32'(bus.mem_rdata) : 32'd0);
        chk("dm_rdata",  bus.dm_rdata, e_dmd ? 32'(bus.mem_rdata) : 32'd0);
        chk("if_stall",  bus.if_stall, 32'(bus.if_req && !e_ifd));
        chk("dm_stall",  bus.dm_stall, 32'(bus.dm_req && !e_dmd));
        chk("err",       bus.err, 32'(m_err));
        if (log_en) begin
          if (bus.if_done === 1'b1) done_log.push_back(1'b0);
          if (bus.dm_done === 1'b1) done_log.push_back(1'b1);
        end
        m_ifd_prev = e_ifd;
        m_dmd_prev = e_dmd;
        // Advance the model by one clock edge.
        if (!m_busy && bus.mem_ready) m_err = 1'b1;
        if (m_busy) begin
          if (bus.mem_ready) m_busy = 1'b0;
        end else begin
          take_if = bus.if_req && (!bus.dm_req || (FAIR && m_starve == SMAX));
          if (take_if) begin
            m_busy = 1'b1; m_who_dm = 1'b0; m_wr = 1'b0; m_addr = bus.if_addr;
            m_starve = 0; m_gcnt++;
          end else if (bus.dm_req) begin
            m_busy = 1'b1; m_who_dm = 1'b1; m_wr = bus.dm_wr;
            m_addr = bus.dm_addr; m_wdata = bus.dm_wdata;
            if (FAIR && bus.if_req && m_starve < SMAX) m_starve++;
            m_gcnt++;
          end
          if (m_busy && m_addr[0]) m_err = 1'b1;
        end
      end
    end
  end

  // Stimulus controls.
  int          lat_min = 0;
  int          lat_max = 0;
  int          wait_left = 0;
  int          seen_g = 0;
  bit          spur_en = 1'b0;
  bit          rand_mode = 1'b0;
  logic [15:0] last_rdata = 16'h0000;

  task automatic rand_req();
    logic [31:0] r;
    if (rst == 1'b0) rst = 1'b1;
    else if ($urandom_range(149, 0) == 0) rst = 1'b0;
    if (m_ifd_prev || !bus.if_req) begin
      r = $urandom;
      bus.if_req  = r[20];
      bus.if_addr = {r[15:1], ($urandom_range(15, 0) == 0)};
    end
    if (m_dmd_prev || !bus.dm_req) begin
      r = $urandom;
      bus.dm_req   = r[20];
      bus.dm_wr    = r[21];
      bus.dm_addr  = {r[15:1], ($urandom_range(15, 0) == 0)};
      bus.dm_wdata = 16'($urandom);
    end else if (m_busy && m_who_dm && $urandom_range(3, 0) == 0) begin
      r = $urandom;
      bus.dm_addr  = r[15:0];
      bus.dm_wdata = r[31:16];
    end
  endtask

  // One clock: memory model responds, then random requesters if enabled.
  task automatic tick();
    @(posedge clk);
    #1;
    if (m_busy) begin
      if (m_gcnt != seen_g) begin
        seen_g = m_gcnt;
        wait_left = $urandom_range(lat_max, lat_min);
      end
      if (wait_left == 0) begin
        bus.mem_ready = 1'b1;
        last_rdata = 16'($urandom);
        bus.mem_rdata = last_rdata;
      end else begin
        bus.mem_ready = 1'b0;
        wait_left--;
      end
    end else begin
      bus.mem_ready = spur_en && ($urandom_range(59, 0) == 0);
      bus.mem_rdata = 16'($urandom);
    end
    if (rand_mode) rand_req();
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b0;
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    bus.if_req = 1'b0; bus.if_addr = 16'h0000;
    bus.dm_req = 1'b0; bus.dm_wr = 1'b0; bus.dm_addr = 16'h0000; bus.dm_wdata = 16'h0000;
    bus.mem_ready = 1'b0; bus.mem_rdata = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("init_mem_en", bus.mem_en, 32'd0);
    chk("init_addr", bus.mem_addr, 32'd0);
    chk("init_err", bus.err, 32'd0);
    tick();
    rst = 1'b1;

    // Lone fetch, one wait cycle.
    lat_min = 1; lat_max = 1;
    tick(); bus.if_req = 1'b1; bus.if_addr = 16'h0010; #1;
    chk("t1_c0_stall", bus.if_stall, 32'd1);
    chk("t1_c0_en", bus.mem_en, 32'd0);
    tick(); #1;
    chk("t1_c1_en", bus.mem_en, 32'd1);
    chk("t1_c1_addr", bus.mem_addr, 32'h0010);
    chk("t1_c1_done", bus.if_done, 32'd0);
    chk("t1_c1_stall", bus.if_stall, 32'd1);
    tick(); #1;
    chk("t1_c2_done", bus.if_done, 32'd1);
    chk("t1_c2_rdata", bus.if_rdata, 32'(last_rdata));
    chk("t1_c2_stall", bus.if_stall, 32'd0);
    tick(); bus.if_req = 1'b0; #1;
    chk("t1_c3_en", bus.mem_en, 32'd0);

    // Simultaneous store and fetch, zero-wait memory.
    lat_min = 0; lat_max = 0;
    tick();
    bus.dm_req = 1'b1; bus.dm_wr = 1'b1; bus.dm_addr = 16'h0020; bus.dm_wdata = 16'hBEEF;
    bus.if_req = 1'b1; bus.if_addr = 16'h0030; #1;
    chk("t2_c0_dstall", bus.dm_stall, 32'd1);
    tick(); #1;
    chk("t2_c1_en", bus.mem_en, 32'd1);
    chk("t2_c1_wr", bus.mem_wr, 32'd1);
    chk("t2_c1_addr", bus.mem_addr, 32'h0020);
    chk("t2_c1_wdata", bus.mem_wdata, 32'hBEEF);
    chk("t2_c1_ddone", bus.dm_done, 32'd1);
    chk("t2_c1_istall", bus.if_stall, 32'd1);
    tick(); bus.dm_req = 1'b0; #1;
    chk("t2_c2_bubble", bus.mem_en, 32'd0);
    tick(); #1;
    chk("t2_c3_wr", bus.mem_wr, 32'd0);
    chk("t2_c3_addr", bus.mem_addr, 32'h0030);
    chk("t2_c3_idone", bus.if_done, 32'd1);
    tick(); bus.if_req = 1'b0; bus.dm_wr = 1'b0;

    // Address change while the load is in flight.
    lat_min = 2; lat_max = 2;
    tick(); bus.dm_req = 1'b1; bus.dm_wr = 1'b0; bus.dm_addr = 16'h0020;
    tick(); bus.dm_addr = 16'h0040; #1;
    chk("t3_c1_addr", bus.mem_addr, 32'h0020);
    tick(); #1;
    chk("t3_c2_addr", bus.mem_addr, 32'h0020);
    chk("t3_c2_done", bus.dm_done, 32'd0);
    tick(); #1;
    chk("t3_c3_addr", bus.mem_addr, 32'h0020);
    chk("t3_c3_done", bus.dm_done, 32'd1);
    chk("t3_c3_rdata", bus.dm_rdata, 32'(last_rdata));
    tick(); bus.dm_req = 1'b0;

    // Both requesting continuously: grant pattern.
    do_reset();
    lat_min = 0; lat_max = 0;
    tick();
    bus.if_req = 1'b1; bus.if_addr = 16'h0100;
    bus.dm_req = 1'b1; bus.dm_wr = 1'b0; bus.dm_addr = 16'h0200;
    log_en = 1'b1;
    repeat (30) tick();
    log_en = 1'b0; bus.if_req = 1'b0; bus.dm_req = 1'b0;
    tick();
    chk("t4_count", 32'(done_log.size() >= 10), 32'd1);
    for (int i = 0; i < 10; i++) begin
      if (i < done_log.size())
        chk($sformatf("t4_grant%0d", i), 32'(done_log[i]),
            32'((FAIR && (i % 5 == 4)) ? 1'b0 : 1'b1));
    end

    // Completion while idle, then an unaligned access.
    do_reset();
    tick(); bus.mem_ready = 1'b1; #1;
    chk("t5_err_pre", bus.err, 32'd0);
    tick(); #1;
    chk("t5_err_set", bus.err, 32'd1);
    repeat (3) tick(); #1;
    chk("t5_err_sticky", bus.err, 32'd1);
    do_reset();
    tick(); bus.dm_req = 1'b1; bus.dm_wr = 1'b0; bus.dm_addr = 16'h0021; #1;
    chk("t5_odd_pre", bus.err, 32'd0);
    tick(); #1;
    chk("t5_odd_err", bus.err, 32'd1);
    chk("t5_odd_done", bus.dm_done, 32'd1);
    chk("t5_odd_addr", bus.mem_addr, 32'h0021);
    tick(); bus.dm_req = 1'b0;

    // Reset in the middle of a store.
    do_reset();
    lat_min = 3; lat_max = 3;
    tick(); bus.dm_req = 1'b1; bus.dm_wr = 1'b1; bus.dm_addr = 16'h0044; bus.dm_wdata = 16'h1234;
    tick(); #1;
    chk("t6_busy", bus.mem_en, 32'd1);
    tick(); rst = 1'b0; bus.dm_req = 1'b0; #1;
    chk("t6_en_drop", bus.mem_en, 32'd0);
    chk("t6_done_drop", bus.dm_done, 32'd0);
    chk("t6_wr_drop", bus.mem_wr, 32'd0);
    tick(); rst = 1'b1; #1;
    chk("t6_err_rel", bus.err, 32'd0);
    repeat (3) tick(); #1;
    chk("t6_idle", bus.mem_en, 32'd0);

    // Randomized traffic against the model.
    do_reset();
    lat_min = 0; lat_max = 3; spur_en = 1'b1; rand_mode = 1'b1;
    repeat (4000) tick();
    rand_mode = 1'b0;
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
